// File: rtl/mult_dot_accumulator.sv
// Sums the array multiplier's product stream into dot-product results. Operand-side
// valid/last tags are delayed to line up with their products, since the multiplier carries no framing.
module mult_dot_accumulator #(
    parameter int WIDTH     = 8,
    parameter int LATENCY   = 8,
    parameter int ACC_WIDTH = 20,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_valid,
    input  logic                 op_last,
    input  logic [WIDTH-1:0]     prod,
    output logic [ACC_WIDTH-1:0] res_data,
    output logic [CNT_WIDTH-1:0] res_count,
    output logic                 res_ovf,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 overrun,
    output logic                 dbg_state
);
    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;
    state_t state, state_nxt;

    logic [LATENCY-1:0]   v_sr, l_sr;
    logic                 v_al, l_al;
    logic [ACC_WIDTH-1:0] acc, acc_nxt, base_acc, sum;
    logic [ACC_WIDTH:0]   sum_wide;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt, base_cnt, term_cnt;
    logic                 gov, gov_nxt, base_gov, term_gov;
    logic                 sat, complete, load;

    // last is gated by valid on entry so an unqualified op_last never frames a group
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sr <= '0;
            l_sr <= '0;
        end else begin
            v_sr <= (v_sr << 1) | LATENCY'(op_valid);
            l_sr <= (l_sr << 1) | LATENCY'(op_last & op_valid);
        end
    end

    assign v_al = v_sr[LATENCY-1];
    assign l_al = l_sr[LATENCY-1];

    // In IDLE a term starts from zero, so one adder serves both the first and later terms
    always_comb begin
        base_acc = '0;
        base_cnt = '0;
        base_gov = 1'b0;
        case (state)
            ACCUM: begin
                base_acc = acc;
                base_cnt = cnt;
                base_gov = gov;
            end
            default: ;
        endcase
    end

    assign sum_wide = {1'b0, base_acc} + (ACC_WIDTH+1)'(prod);
    assign sat      = sum_wide[ACC_WIDTH];
    assign sum      = sat ? '1 : sum_wide[ACC_WIDTH-1:0];
    assign term_gov = base_gov | sat;
    assign term_cnt = (&base_cnt) ? base_cnt : base_cnt + CNT_WIDTH'(1);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        gov_nxt   = gov;
        complete  = 1'b0;
        if (v_al) begin
            if (l_al) begin
                complete  = 1'b1;
                state_nxt = IDLE;
                acc_nxt   = '0;
                cnt_nxt   = '0;
                gov_nxt   = 1'b0;
            end else begin
                state_nxt = ACCUM;
                acc_nxt   = sum;
                cnt_nxt   = term_cnt;
                gov_nxt   = term_gov;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            gov   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            gov   <= gov_nxt;
        end
    end

    // Result handshake: a result transfers on any rising edge where res_valid and res_ready
    // are both high; while res_valid=1 and res_ready=0 the result fields hold steady. A
    // completion that finds the register full and not draining is dropped and flagged.
    assign load = complete & (~res_valid | res_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data  <= '0;
            res_count <= '0;
            res_ovf   <= 1'b0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                res_data  <= sum;
                res_count <= term_cnt;
                res_ovf   <= term_gov;
            end
            if (load)
                res_valid <= 1'b1;
            else if (res_valid & res_ready)
                res_valid <= 1'b0;
            if (complete & ~load)
                overrun <= 1'b1;
        end
    end

    assign dbg_state = (state == ACCUM);

endmodule

// File: tb/tb_mult_dot_accumulator.sv
// Bench for mult_dot_accumulator: a delay-line multiplier stand-in feeds prod, a group-level
// reference model predicts each result and its arrival edge, and directed vectors cover corners.
module tb_mult_dot_accumulator;
    localparam int W       = 8;
    localparam int LAT     = 8;
    localparam int AW      = 10;
    localparam int CW      = 4;
    localparam int ACC_MAX = (1 << AW) - 1;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int EW      = AW + CW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_last = 1'b0;
    logic          res_ready = 1'b0;
    logic [W-1:0]  prod = '0;
    logic [AW-1:0] res_data;
    logic [CW-1:0] res_count;
    logic          res_ovf, res_valid, overrun, dbg_state;

    mult_dot_accumulator #(.WIDTH(W), .LATENCY(LAT), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_last(op_last), .prod(prod),
        .res_data(res_data), .res_count(res_count), .res_ovf(res_ovf), .res_valid(res_valid),
        .res_ready(res_ready), .overrun(overrun), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [W-1:0] hist [LAT];

    // Reference model: group totals are formed per operand, results are due LAT+1 edges later
    logic [EW-1:0] exp_q[$];
    int            due_q[$];
    int            g_sum, g_cnt;
    logic          g_ovf;
    logic          m_valid, m_ovr;
    logic [EW-1:0] m_res;

    typedef struct packed {
        logic [2:0]       n;
        logic [4:0]       gap;
        logic [4:0][15:0] ab;
        logic [AW-1:0]    e_data;
        logic [CW-1:0]    e_cnt;
        logic             e_ovf;
    } vec_t;
    vec_t vecs[7];

    function automatic vec_t mk(input int n, input int gap, input logic [4:0][15:0] ab,
                                input int ed, input int ec, input logic eo);
        vec_t v;
        v.n = 3'(n);
        v.gap = 5'(gap);
        v.ab = ab;
        v.e_data = AW'(ed);
        v.e_cnt = CW'(ec);
        v.e_ovf = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        g_sum = 0;
        g_cnt = 0;
        g_ovf = 1'b0;
        exp_q.delete();
        due_q.delete();
        m_valid = 1'b0;
        m_ovr = 1'b0;
        m_res = '0;
    endtask

    task automatic model_operand(input logic last, input logic [W-1:0] p);
        g_sum += int'(p);
        if (g_sum > ACC_MAX) begin
            g_sum = ACC_MAX;
            g_ovf = 1'b1;
        end
        if (g_cnt < CNT_MAX) g_cnt++;
        if (last) begin
            exp_q.push_back({AW'(g_sum), CW'(g_cnt), g_ovf});
            due_q.push_back(cyc + LAT + 1);
            g_sum = 0;
            g_cnt = 0;
            g_ovf = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [EW-1:0] r;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            r = exp_q.pop_front();
            due_q.delete(0);
            if (m_valid && !res_ready) m_ovr = 1'b1;
            else begin
                m_valid = 1'b1;
                m_res = r;
            end
        end else if (m_valid && res_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_count", 32'(res_count), 32'd0);
        chk("rst_res_ovf", 32'(res_ovf), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_dbg_state", 32'(dbg_state), 32'd0);
    endtask

    task automatic check_cycle();
        if (!rst_n) check_reset_outputs();
        else begin
            chk("res_valid", 32'(res_valid), 32'(m_valid));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            if (m_valid) begin
                chk("res_data", 32'(res_data), 32'(m_res[EW-1:CW+1]));
                chk("res_count", 32'(res_count), 32'(m_res[CW:1]));
                chk("res_ovf", 32'(res_ovf), 32'(m_res[0]));
            end
        end
    endtask

    // One clock: update the model for this edge, compare, then drive the next inputs
    task automatic tick(input logic v, input logic l, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic rdy);
        logic [2*W-1:0] p;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_cycle();
        prod = hist[LAT-1];
        for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
        p = a * b;
        hist[0] = p[W-1:0];
        op_valid = v;
        op_last = l;
        res_ready = rdy;
        if (v && rst_n) model_operand(l, p[W-1:0]);
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) tick(1'b0, 1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
                        W'($urandom_range(0, 255)), rdy);
    endtask

    task automatic wait_valid(input int maxc, input logic rdy, output int n);
        n = 0;
        while (res_valid !== 1'b1 && n < maxc) begin
            idle(1, rdy);
            n++;
        end
        chk("res_valid_seen", 32'(res_valid), 32'd1);
    endtask

    initial begin
        int nw;
        int n;
        for (int i = 0; i < LAT; i++) hist[i] = '0;
        model_reset();

        // ab[0] is the rightmost pair
        vecs[0] = mk(1, 0, {16'h0, 16'h0, 16'h0, 16'h0, {8'd2, 8'd9}}, 18, 1, 1'b0);
        vecs[1] = mk(3, 5'b00010, {16'h0, 16'h0, {8'd7, 8'd8}, {8'd5, 8'd6}, {8'd3, 8'd4}}, 98, 3, 1'b0);
        vecs[2] = mk(5, 0, {{8'd15, 8'd17}, {8'd15, 8'd17}, {8'd15, 8'd17}, {8'd15, 8'd17},
                            {8'd15, 8'd17}}, 1023, 5, 1'b1);
        vecs[3] = mk(1, 0, {16'h0, 16'h0, 16'h0, 16'h0, {8'd1, 8'd1}}, 1, 1, 1'b0);
        vecs[4] = mk(2, 0, {16'h0, 16'h0, 16'h0, {8'd3, 8'd3}, {8'd16, 8'd16}}, 9, 2, 1'b0);
        vecs[5] = mk(2, 0, {16'h0, 16'h0, 16'h0, {8'd20, 8'd20}, {8'd31, 8'd31}}, 337, 2, 1'b0);
        vecs[6] = mk(5, 0, {{8'd1, 8'd2}, {8'd15, 8'd17}, {8'd15, 8'd17}, {8'd15, 8'd17},
                            {8'd15, 8'd17}}, 1022, 5, 1'b0);

        repeat (3) tick(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        rst_n = 1'b1;
        idle(2, 1'b1);

        for (int k = 0; k < 7; k++) begin
            n = int'(vecs[k].n);
            for (int i = 0; i < n; i++) begin
                if (vecs[k].gap[i]) idle(1, 1'b1);
                tick(1'b1, (i == n - 1), vecs[k].ab[i][15:8], vecs[k].ab[i][7:0], 1'b1);
            end
            wait_valid(LAT + 4, 1'b1, nw);
            if (k == 0) chk("latency", 32'(nw), 32'(LAT + 1));
            chk("vec_data", 32'(res_data), 32'(vecs[k].e_data));
            chk("vec_count", 32'(res_count), 32'(vecs[k].e_cnt));
            chk("vec_ovf", 32'(res_ovf), 32'(vecs[k].e_ovf));
            idle(2, 1'b1);
        end

        // Back-to-back single-term groups
        tick(1'b1, 1'b1, 8'd1, 8'd1, 1'b1);
        tick(1'b1, 1'b1, 8'd2, 8'd2, 1'b1);
        wait_valid(LAT + 4, 1'b1, nw);
        chk("b2b_first", 32'(res_data), 32'd1);
        chk("b2b_first_cnt", 32'(res_count), 32'd1);
        idle(1, 1'b1);
        chk("b2b_second_valid", 32'(res_valid), 32'd1);
        chk("b2b_second", 32'(res_data), 32'd4);
        chk("b2b_second_cnt", 32'(res_count), 32'd1);
        idle(2, 1'b1);

        // Completion on the same edge as a transfer replaces the result without overrun
        tick(1'b1, 1'b1, 8'd3, 8'd4, 1'b0);
        idle(2, 1'b0);
        tick(1'b1, 1'b1, 8'd5, 8'd6, 1'b0);
        idle(7, 1'b0);
        tick(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
        chk("same_edge_held", 32'(res_data), 32'd12);
        idle(1, 1'b1);
        chk("same_edge_valid", 32'(res_valid), 32'd1);
        chk("same_edge_data", 32'(res_data), 32'd30);
        chk("same_edge_overrun", 32'(overrun), 32'd0);
        idle(2, 1'b1);

        // Second completion while stalled is dropped and flagged
        tick(1'b1, 1'b1, 8'd3, 8'd4, 1'b0);
        idle(1, 1'b0);
        tick(1'b1, 1'b1, 8'd5, 8'd6, 1'b0);
        idle(10, 1'b0);
        chk("ovr_valid", 32'(res_valid), 32'd1);
        chk("ovr_data", 32'(res_data), 32'd12);
        chk("ovr_flag", 32'(overrun), 32'd1);
        idle(2, 1'b1);
        chk("ovr_drained", 32'(res_valid), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Reset with three terms in flight
        tick(1'b1, 1'b0, 8'd1, 8'd2, 1'b1);
        tick(1'b1, 1'b0, 8'd3, 8'd4, 1'b1);
        tick(1'b1, 1'b0, 8'd5, 8'd6, 1'b1);
        idle(1, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        tick(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
        rst_n = 1'b1;
        tick(1'b1, 1'b1, 8'd2, 8'd3, 1'b1);
        wait_valid(LAT + 4, 1'b1, nw);
        chk("post_rst_data", 32'(res_data), 32'd6);
        chk("post_rst_count", 32'(res_count), 32'd1);
        idle(LAT + 2, 1'b1);

        // Random groups with bubbles, garbage on idle cycles and random backpressure
        for (int g = 0; g < 40; g++) begin
            n = int'($urandom_range(1, 18));
            for (int t = 0; t < n; t++) begin
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
                tick(1'b1, (t == n - 1), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                     ($urandom_range(0, 3) != 0));
            end
            idle(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        idle(LAT + 4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
